// File: rtl/out_bank_ring_ctrl.sv
// Output buffer bank ring controller.
// Watches the engine's AXIS output stream. When a packet ends and the next
// bank in the ring has been released by the PS, it issues one write
// descriptor for that bank. It then tracks the DMA write status and raises a
// completion interrupt once the last outstanding write has finished.
//
// Descriptor handshake (m_od_*): m_od_valid rises the cycle after an issue.
// While it is high, addr/len/tag stay stable. The transfer happens on a cycle
// where m_od_valid and m_od_ready are both high, and m_od_valid drops on the
// following cycle. No new descriptor is issued while one is pending.
module out_bank_ring_ctrl #(
   parameter int N_BANKS = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 32,
   parameter int TAG_W   = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              reg_wr_en,
   input  logic [ADDR_W-1:0] reg_wr_addr,
   input  logic [DATA_W-1:0] reg_wr_data,
   input  logic              reg_rd_en,
   input  logic [ADDR_W-1:0] reg_rd_addr,
   output logic              reg_rd_ack,
   output logic [DATA_W-1:0] reg_rd_data,
   input  logic              o_valid,
   input  logic              o_ready,
   input  logic              o_last,
   input  logic [LEN_W-1:0]  o_bpt,
   output logic [ADDR_W-1:0] m_od_addr,
   output logic [LEN_W-1:0]  m_od_len,
   output logic [TAG_W-1:0]  m_od_tag,
   output logic              m_od_valid,
   input  logic              m_od_ready,
   input  logic [TAG_W-1:0]  os_tag,
   input  logic [3:0]        os_error,
   input  logic              os_valid,
   output logic              irq_done
);

   localparam int IDX_W = $clog2(N_BANKS);
   localparam int CNT_W = 16;
   localparam int PG_W  = ADDR_W - 4;
   localparam logic [4:0]       NB       = 5'(N_BANKS);
   localparam logic [TAG_W:0]   NB_TAG   = (TAG_W+1)'(N_BANKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BANKS - 1);

   // state registers
   logic [ADDR_W-1:0]  ocm_base_q [N_BANKS];
   logic [ADDR_W-1:0]  ocm_base_d [N_BANKS];
   logic [N_BANKS-1:0] done_read_q, done_read_d;
   logic [N_BANKS-1:0] done_write_q, done_write_d;
   logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
   logic               got_o_last_q, got_o_last_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic               m_od_valid_q, m_od_valid_d;
   logic [ADDR_W-1:0]  m_od_addr_q, m_od_addr_d;
   logic [LEN_W-1:0]   m_od_len_q, m_od_len_d;
   logic [TAG_W-1:0]   m_od_tag_q, m_od_tag_d;
   logic               o_done_q, o_done_d;
   logic               err_q, err_d;
   logic [TAG_W-1:0]   err_tag_q, err_tag_d;
   logic [3:0]         err_code_q, err_code_d;
   logic               irq_q, irq_d;
   logic               rd_ack_q;
   logic [DATA_W-1:0]  rd_data_q, rd_mux;

   // decoded control terms
   logic [PG_W-1:0]    wr_page, rd_page;
   logic [3:0]         wr_sub, rd_sub;
   logic               wr_sub_ok, rd_sub_ok;
   logic               wr_ctrl, wr_base, wr_dr, start;
   logic [IDX_W-1:0]   next_idx;
   logic               issue, st_good, st_bad, beat_last;

   assign wr_page   = reg_wr_addr[ADDR_W-1:4];
   assign rd_page   = reg_rd_addr[ADDR_W-1:4];
   assign wr_sub    = reg_wr_addr[3:0];
   assign rd_sub    = reg_rd_addr[3:0];
   assign wr_sub_ok = ({1'b0, wr_sub} < NB);
   assign rd_sub_ok = ({1'b0, rd_sub} < NB);
   assign wr_ctrl   = reg_wr_en && (reg_wr_addr == '0);
   assign wr_base   = reg_wr_en && (wr_page == PG_W'(1)) && wr_sub_ok;
   assign wr_dr     = reg_wr_en && (wr_page == PG_W'(2)) && wr_sub_ok;
   assign start     = wr_ctrl && reg_wr_data[0];

   assign next_idx  = (cur_idx_q == LAST_IDX) ? '0 : cur_idx_q + 1'b1;
   // start takes priority over a same-cycle issue so the ring restarts cleanly
   assign issue     = o_valid && got_o_last_q && done_read_q[next_idx] &&
                      !m_od_valid_q && !start;
   assign st_good   = os_valid && (os_error == 4'd0) && ({1'b0, os_tag} < NB_TAG);
   assign st_bad    = os_valid && !st_good;
   assign beat_last = o_valid && o_ready && o_last;

   assign m_od_valid  = m_od_valid_q;
   assign m_od_addr   = m_od_addr_q;
   assign m_od_len    = m_od_len_q;
   assign m_od_tag    = m_od_tag_q;
   assign irq_done    = irq_q;
   assign reg_rd_ack  = rd_ack_q;
   assign reg_rd_data = rd_data_q;

   // next-state logic for ring, descriptor, status tracking and PS writes
   always_comb begin
      ocm_base_d    = ocm_base_q;
      done_read_d   = done_read_q;
      done_write_d  = done_write_q;
      cur_idx_d     = cur_idx_q;
      got_o_last_d  = got_o_last_q;
      outstanding_d = outstanding_q;
      m_od_valid_d  = m_od_valid_q;
      m_od_addr_d   = m_od_addr_q;
      m_od_len_d    = m_od_len_q;
      m_od_tag_d    = m_od_tag_q;
      o_done_d      = o_done_q;
      err_d         = err_q;
      err_tag_d     = err_tag_q;
      err_code_d    = err_code_q;

      if (m_od_valid_q && m_od_ready) m_od_valid_d = 1'b0;

      if (issue) begin
         m_od_valid_d           = 1'b1;
         m_od_addr_d            = ocm_base_q[next_idx];
         m_od_len_d             = o_bpt;
         m_od_tag_d             = TAG_W'(next_idx);
         cur_idx_d              = next_idx;
         done_read_d[next_idx]  = 1'b0;
         done_write_d[next_idx] = 1'b0;
         got_o_last_d           = 1'b0;
      end
      // a last beat in the issue cycle belongs to the packet just described
      if (beat_last) got_o_last_d = 1'b1;

      if (st_good) begin
         for (int i = 0; i < N_BANKS; i++) begin
            if (os_tag == TAG_W'(i)) done_write_d[i] = 1'b1;
         end
      end
      if (st_bad) begin
         err_d = 1'b1;
         if (!err_q) begin
            err_tag_d  = os_tag;
            err_code_d = os_error;
         end
      end

      if (issue && !os_valid) outstanding_d = outstanding_q + 1'b1;
      else if (!issue && os_valid && (outstanding_q != '0)) outstanding_d = outstanding_q - 1'b1;

      if (os_valid && got_o_last_q && !issue && (outstanding_q == CNT_W'(1))) o_done_d = 1'b1;
      if (o_valid) o_done_d = 1'b0;

      // PS writes are applied after the hardware clear so the PS value wins
      for (int i = 0; i < N_BANKS; i++) begin
         if (wr_base && (wr_sub == 4'(i))) ocm_base_d[i] = ADDR_W'(reg_wr_data);
         if (wr_dr && (wr_sub == 4'(i)))   done_read_d[i] = reg_wr_data[0];
      end

      if (start) begin
         cur_idx_d     = LAST_IDX;
         got_o_last_d  = 1'b1;
         outstanding_d = '0;
         m_od_valid_d  = 1'b0;
         o_done_d      = 1'b0;
         err_d         = 1'b0;
         done_read_d   = '1;
         done_write_d  = '0;
      end

      irq_d = o_done_d && !o_done_q;
   end

   // register read mux; unmapped or out-of-range addresses read as zero
   always_comb begin
      rd_mux = '0;
      if (reg_rd_addr == ADDR_W'(1))
         rd_mux = DATA_W'({4'(cur_idx_q), 6'd0, err_q, o_done_q});
      else if (reg_rd_addr == ADDR_W'(2))
         rd_mux = DATA_W'({err_tag_q, err_code_q});
      else if ((rd_page == PG_W'(1)) && rd_sub_ok)
         rd_mux = DATA_W'(ocm_base_q[rd_sub[IDX_W-1:0]]);
      else if ((rd_page == PG_W'(2)) && rd_sub_ok)
         rd_mux = DATA_W'(done_read_q[rd_sub[IDX_W-1:0]]);
      else if ((rd_page == PG_W'(3)) && rd_sub_ok)
         rd_mux = DATA_W'(done_write_q[rd_sub[IDX_W-1:0]]);
   end

   // state update with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < N_BANKS; i++) ocm_base_q[i] <= '0;
         done_read_q   <= '1;
         done_write_q  <= '0;
         cur_idx_q     <= LAST_IDX;
         got_o_last_q  <= 1'b1;
         outstanding_q <= '0;
         m_od_valid_q  <= 1'b0;
         m_od_addr_q   <= '0;
         m_od_len_q    <= '0;
         m_od_tag_q    <= '0;
         o_done_q      <= 1'b0;
         err_q         <= 1'b0;
         err_tag_q     <= '0;
         err_code_q    <= '0;
         irq_q         <= 1'b0;
         rd_ack_q      <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         ocm_base_q    <= ocm_base_d;
         done_read_q   <= done_read_d;
         done_write_q  <= done_write_d;
         cur_idx_q     <= cur_idx_d;
         got_o_last_q  <= got_o_last_d;
         outstanding_q <= outstanding_d;
         m_od_valid_q  <= m_od_valid_d;
         m_od_addr_q   <= m_od_addr_d;
         m_od_len_q    <= m_od_len_d;
         m_od_tag_q    <= m_od_tag_d;
         o_done_q      <= o_done_d;
         err_q         <= err_d;
         err_tag_q     <= err_tag_d;
         err_code_q    <= err_code_d;
         irq_q         <= irq_d;
         rd_ack_q      <= reg_rd_en;
         rd_data_q     <= rd_mux;
      end
   end

endmodule
